// File: rtl/tdm_pkg.sv
// Shared types and constants for the tdm_demux4 receive datapath.
// Frame-lock FSM states and the width of the optional error counter.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_e;

    localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/tdm_demux4_if.sv
// TDM word stream from the serial link into tdm_demux4.
// master drives the stream, slave (the demux) consumes it.
interface tdm_demux4_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             frame_sync;

    modport master (output in_data, output in_valid, output frame_sync);
    modport slave  (input  in_data, input  in_valid, input  frame_sync);
endinterface

// File: rtl/tdm_slot_ctr.sv
// Rotating mod-NUM_CH slot counter that replaces an external select.
// Priority: clear (back to slot 0) > load-to-1 (resync on slot-0 word) > advance.
module tdm_slot_ctr #(
    parameter  int NUM_CH = 4,
    localparam int SLOT_W = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load1,
    input  logic              en,
    output logic [SLOT_W-1:0] slot,
    output logic              last_slot
);

    logic [SLOT_W-1:0] slot_reg;

    // Slot index register: wraps from NUM_CH-1 back to 0 on advance.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            slot_reg <= '0;
        end else if (load1) begin
            slot_reg <= SLOT_W'(1);
        end else if (en) begin
            slot_reg <= last_slot ? '0 : slot_reg + SLOT_W'(1);
        end
    end

    assign slot      = slot_reg;
    assign last_slot = (slot_reg == SLOT_W'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux4.sv
// TDM demultiplexer: distributes consecutive words of one stream to NUM_CH
// registered channel outputs, tracking frame lock from the slot-0 frame_sync.
// Optional feature macro: TDM_DEMUX_ERR_CNT_EN adds the saturating err_cnt port
// counting misalignment events and missing slot-0 syncs.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_CH   = 4,
    parameter int MISS_MAX = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tdm_demux4_if.slave             in_if,
    output logic [NUM_CH*WIDTH-1:0] ch_data,
    output logic [NUM_CH-1:0]       ch_valid,
    output logic                    frame_done,
    output logic                    locked
`ifdef TDM_DEMUX_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]    err_cnt
`endif
);

    localparam int SLOT_W = $clog2(NUM_CH);
    localparam int MISS_W = $clog2(MISS_MAX + 1);
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

    tdm_state_e        state_reg, state_next;
    logic [MISS_W-1:0] miss_reg, miss_next;
    logic [SLOT_W-1:0] slot;
    logic              last_slot;
    logic              ctr_clr, ctr_load1, ctr_en;
    logic              cap_en;
    logic [SLOT_W-1:0] cap_slot;
    logic              done_next;
    logic [NUM_CH-1:0] ch_valid_reg;
    logic              frame_done_reg;

    tdm_slot_ctr #(.NUM_CH(NUM_CH)) u_slot_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (ctr_clr),
        .load1     (ctr_load1),
        .en        (ctr_en),
        .slot      (slot),
        .last_slot (last_slot)
    );

    // State and miss-counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= HUNT;
            miss_reg  <= '0;
        end else begin
            state_reg <= state_next;
            miss_reg  <= miss_next;
        end
    end

    // Next-state, capture selection and slot-counter control for each beat.
    always_comb begin
        state_next = state_reg;
        miss_next  = miss_reg;
        ctr_clr    = 1'b0;
        ctr_load1  = 1'b0;
        ctr_en     = 1'b0;
        cap_en     = 1'b0;
        cap_slot   = '0;
        done_next  = 1'b0;
        if (in_if.in_valid) begin
            case (state_reg)
                HUNT: begin
                    if (in_if.frame_sync) begin
                        cap_en     = 1'b1;
                        ctr_load1  = 1'b1;
                        state_next = LOCKED;
                        miss_next  = '0;
                    end
                end
                LOCKED: begin
                    if (in_if.frame_sync && slot != '0) begin
                        // Sync arrived mid-frame: restart the frame at slot 0,
                        // the truncated frame never reports frame_done.
                        cap_en    = 1'b1;
                        ctr_load1 = 1'b1;
                        miss_next = '0;
                    end else begin
                        cap_en    = 1'b1;
                        cap_slot  = slot;
                        ctr_en    = 1'b1;
                        done_next = last_slot;
                        if (slot == '0) begin
                            if (in_if.frame_sync) begin
                                miss_next = '0;
                            end else if (miss_reg == MISS_LAST) begin
                                // Word is still delivered before dropping lock.
                                state_next = HUNT;
                                ctr_clr    = 1'b1;
                                miss_next  = '0;
                            end else begin
                                miss_next = miss_reg + MISS_W'(1);
                            end
                        end
                    end
                end
                default: state_next = HUNT;
            endcase
        end
    end

    // Per-channel data registers; untouched channels hold their value.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [WIDTH-1:0] data_reg;

        // Capture the beat word when it is addressed to this channel.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_reg <= '0;
            end else if (cap_en && cap_slot == SLOT_W'(gi)) begin
                data_reg <= in_if.in_data;
            end
        end

        assign ch_data[gi*WIDTH +: WIDTH] = data_reg;
    end

    // One-cycle update pulses aligned with the captured data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_valid_reg   <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            ch_valid_reg   <= cap_en ? (NUM_CH'(1) << cap_slot) : '0;
            frame_done_reg <= done_next;
        end
    end

    assign ch_valid   = ch_valid_reg;
    assign frame_done = frame_done_reg;
    assign locked     = (state_reg == LOCKED);

`ifdef TDM_DEMUX_ERR_CNT_EN
    logic                 err_inc;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    assign err_inc = in_if.in_valid && (state_reg == LOCKED) &&
                     (in_if.frame_sync ? (slot != '0) : (slot == '0));

    // Saturating count of misalignments and missing slot-0 syncs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (err_inc && err_cnt_reg != '1) begin
            err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

endmodule
